imm_extend_unit: RTL
====================

# imm_extend_unit

Parametrised, registered operand-extension stage for the MIPS datapath. It widens a shift amount or 16-bit immediate to the datapath width in one of four modes: shamt zero-extend, immediate sign-extend, immediate zero-extend, or upper-immediate placement. It sits between decode and the ALU operand mux. A valid/ready handshake and a 2-entry output buffer let it absorb one cycle of downstream stall without dropping or duplicating operands.

## Interface
Parameters:
- DATA_W, 32, output operand width; must be >= IMM_W and >= SHAMT_W
- IMM_W, 16, immediate field width
- SHAMT_W, 5, shift-amount field width
- TAG_W, 5, sideband tag (destination register) carried with each operand

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- in_valid  input  1  request present
- in_ready  output  1  stage can accept a request this cycle
- in_mode  input  2  00 shamt zero-ext, 01 imm sign-ext, 10 imm zero-ext, 11 upper-imm
- in_shamt  input  SHAMT_W  shift amount field
- in_imm  input  IMM_W  immediate field
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head this cycle
- out_data  output  DATA_W  extended operand of head entry
- out_tag  output  TAG_W  tag of head entry
- out_count  output  2  entries held (0..2)

## Operation
- Extension, computed combinationally at accept time and stored already extended:
  - mode 00: {zeros, in_shamt}; in_imm ignored
  - mode 01: in_imm sign-extended from bit IMM_W-1; in_shamt ignored
  - mode 10: {zeros, in_imm}
  - mode 11: in_imm << (DATA_W-IMM_W); low bits zero
- Buffer: 2-entry FIFO (head, tail), count in {0,1,2}.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != 2). It is a function of registered count only and never depends on out_ready in the same cycle.
- out_valid = (count != 0). out_data and out_tag always reflect the head entry.
- Count transitions:
  - push only: +1
  - pop only: -1
  - push & pop: unchanged; new entry goes behind the popped one
- Count 1, push & pop: the new entry becomes head on the next cycle.
- Count 2: push is impossible (in_ready=0); pop moves tail to head.
- Count 0: a pop is impossible (out_valid=0).
- Entry order is strictly FIFO. Each accepted request emerges exactly once.
- While out_valid=1 and out_ready=0, out_data and out_tag hold stable.

## Timing
- Reset (rst_n=0 at a rising edge):
  - count=0, out_valid=0, in_ready=1, out_count=0
  - out_data=0, out_tag=0 (entry storage cleared)
- Reset has priority over any push or pop in the same cycle.
- Reset mid-operation discards all held entries; nothing in flight is emitted afterwards.
- Latency: a request accepted at edge N is visible on out_* from edge N (i.e., during cycle N+1), provided the buffer was empty or its head pops at edge N.
- Throughput: one operand per cycle sustained while out_ready=1.
- in_ready falls one cycle after the buffer fills and rises one cycle after the first pop from full.
- No combinational path from out_ready to in_ready. in_* reach out_* only through registers.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, out_count=0, out_data=0. After release, the first accepted request appears one cycle later.
- Mode coverage with DATA_W=32, out_ready=1:
  - shamt=5'h1F, mode 00 -> 32'h0000001F
  - imm=16'h8001, mode 01 -> 32'hFFFF8001
  - imm=16'h8001, mode 10 -> 32'h00008001
  - imm=16'h1234, mode 11 -> 32'h12340000
  - Each arrives one cycle after accept, with its tag.
- Back-pressure: hold out_ready=0 and offer tags 1,2,3 back to back.
  - Tags 1 and 2 are accepted; in_ready=0 on the third; out_count=2; out_data is stable.
  - Raise out_ready -> outputs in order 1,2,3, no loss or duplication.
- Simultaneous push/pop at count=1 -> out_count stays 1, the popped entry is replaced by the new one next cycle, continuous stream of 8 operands at 1/cycle.
- Reset mid-stream with out_count=2 -> out_valid=0 next cycle; pre-reset entries are never emitted.
- Parameter sweep DATA_W=64, IMM_W=16: imm=16'hFFFF, mode 01 -> 64'hFFFFFFFFFFFFFFFF; mode 11 -> 64'hFFFF000000000000.

Source files
------------

// File: rtl/imm_extend_unit.sv
// Registered operand-extension stage: widens a shift amount or immediate to DATA_W
// and holds results in a 2-entry FIFO so one cycle of downstream stall is absorbed.
module imm_extend_unit #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_mode,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic [1:0]         out_count
);

    logic [DATA_W-1:0] shamt_zext;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;
    logic [DATA_W-1:0] imm_upper;
    logic [DATA_W-1:0] ext_data;

    // Bitwise construction keeps every mode legal even when DATA_W equals a field width.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_ext
            if (gi < SHAMT_W) begin : g_shamt_lo
                assign shamt_zext[gi] = in_shamt[gi];
            end else begin : g_shamt_hi
                assign shamt_zext[gi] = 1'b0;
            end

            if (gi < IMM_W) begin : g_imm_lo
                assign imm_sext[gi] = in_imm[gi];
                assign imm_zext[gi] = in_imm[gi];
            end else begin : g_imm_hi
                assign imm_sext[gi] = in_imm[IMM_W-1];
                assign imm_zext[gi] = 1'b0;
            end

            if (gi >= DATA_W - IMM_W) begin : g_upper_hi
                assign imm_upper[gi] = in_imm[gi-(DATA_W-IMM_W)];
            end else begin : g_upper_lo
                assign imm_upper[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        ext_data = shamt_zext;
        case (in_mode)
            2'b00:   ext_data = shamt_zext;
            2'b01:   ext_data = imm_sext;
            2'b10:   ext_data = imm_zext;
            default: ext_data = imm_upper;
        endcase
    end

    logic [DATA_W-1:0] head_data_reg, head_data_next;
    logic [TAG_W-1:0]  head_tag_reg,  head_tag_next;
    logic [DATA_W-1:0] tail_data_reg, tail_data_next;
    logic [TAG_W-1:0]  tail_tag_reg,  tail_tag_next;
    logic [1:0]        count_reg,     count_next;
    logic              push;
    logic              pop;

    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = head_data_reg;
    assign out_tag   = head_tag_reg;
    assign out_count = count_reg;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        head_data_next = head_data_reg;
        head_tag_next  = head_tag_reg;
        tail_data_next = tail_data_reg;
        tail_tag_next  = tail_tag_reg;
        count_next     = count_reg;
        case (count_reg)
            2'd0: begin
                if (push) begin
                    head_data_next = ext_data;
                    head_tag_next  = in_tag;
                    count_next     = 2'd1;
                end
            end
            2'd1: begin
                // With a simultaneous pop the new entry goes straight to head.
                if (push && pop) begin
                    head_data_next = ext_data;
                    head_tag_next  = in_tag;
                end else if (push) begin
                    tail_data_next = ext_data;
                    tail_tag_next  = in_tag;
                    count_next     = 2'd2;
                end else if (pop) begin
                    count_next     = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_data_next = tail_data_reg;
                    head_tag_next  = tail_tag_reg;
                    count_next     = 2'd1;
                end
            end
            default: count_next = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_data_reg <= '0;
            head_tag_reg  <= '0;
            tail_data_reg <= '0;
            tail_tag_reg  <= '0;
            count_reg     <= 2'd0;
        end else begin
            head_data_reg <= head_data_next;
            head_tag_reg  <= head_tag_next;
            tail_data_reg <= tail_data_next;
            tail_tag_reg  <= tail_tag_next;
            count_reg     <= count_next;
        end
    end

endmodule
